// File: rtl/arbitro_vc_dest.sv
// Weighted arbiter moving words from the VC0/VC1 FIFOs into the D0/D1 FIFOs.
// VC0 has priority for up to VC0_WEIGHT contended grants in a row; VC1 then gets one.
module arbitro_vc_dest #(
  parameter int BW         = 6,
  parameter int VC0_WEIGHT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             vc0_empty,
  input  logic             vc1_empty,
  input  logic [BW-1:0]    vc0_data,
  input  logic [BW-1:0]    vc1_data,
  input  logic             d0_almost_full,
  input  logic             d1_almost_full,
  output logic             vc0_rd,
  output logic             vc1_rd,
  output logic             d0_wr,
  output logic             d1_wr,
  output logic [BW-1:0]    d0_data,
  output logic [BW-1:0]    d1_data,
  output logic [CNT_W-1:0] d0_count,
  output logic [CNT_W-1:0] d1_count,
  output logic             grant_vc1
);

  localparam int                WCNT_W = 4;
  localparam logic [WCNT_W-1:0] WMAX   = WCNT_W'(VC0_WEIGHT);

  logic              elig0_s;
  logic              elig1_s;
  logic              grant0_s;
  logic              grant1_s;
  logic [BW-1:0]     word_s;
  logic [WCNT_W-1:0] wcnt_r;

  // Eligibility and grant selection from the current heads and destination fullness.
  always_comb begin
    elig0_s  = 1'b0;
    elig1_s  = 1'b0;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    word_s   = {BW{1'b0}};
    // Heads are checked against the fullness of the destination they would land in.
    if (!reset && active && !vc0_empty) begin
      elig0_s = vc0_data[BW-2] ? ~d1_almost_full : ~d0_almost_full;
    end else begin
      elig0_s = 1'b0;
    end
    if (!reset && active && !vc1_empty) begin
      elig1_s = vc1_data[BW-2] ? ~d1_almost_full : ~d0_almost_full;
    end else begin
      elig1_s = 1'b0;
    end
    if (elig0_s && (!elig1_s || (wcnt_r < WMAX))) begin
      grant0_s = 1'b1;
      word_s   = vc0_data;
    end else if (elig1_s) begin
      grant1_s = 1'b1;
      word_s   = vc1_data;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign vc0_rd = grant0_s;
  assign vc1_rd = grant1_s;

  // Weight counter: counts consecutive VC0 grants only while VC1 is contending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_r <= {WCNT_W{1'b0}};
    end else if (grant0_s && elig1_s) begin
      if (wcnt_r < WMAX) begin
        wcnt_r <= wcnt_r + 4'd1;
      end else begin
        wcnt_r <= wcnt_r;
      end
    end else begin
      wcnt_r <= {WCNT_W{1'b0}};
    end
  end

  // Registered push to the destination chosen by the granted word, plus word counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_wr     <= 1'b0;
      d1_wr     <= 1'b0;
      d0_data   <= {BW{1'b0}};
      d1_data   <= {BW{1'b0}};
      d0_count  <= {CNT_W{1'b0}};
      d1_count  <= {CNT_W{1'b0}};
      grant_vc1 <= 1'b0;
    end else begin
      d0_count <= d0_count + {{(CNT_W-1){1'b0}}, d0_wr};
      d1_count <= d1_count + {{(CNT_W-1){1'b0}}, d1_wr};
      d0_wr    <= 1'b0;
      d1_wr    <= 1'b0;
      if (grant0_s || grant1_s) begin
        grant_vc1 <= grant1_s;
        if (word_s[BW-2]) begin
          d1_wr   <= 1'b1;
          d1_data <= word_s;
        end else begin
          d0_wr   <= 1'b1;
          d0_data <= word_s;
        end
      end else begin
        grant_vc1 <= grant_vc1;
      end
    end
  end

endmodule
